// File: rtl/mam_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Holds the FSM state encoding and the burst-length normalisation rule.
package mam_arb_pkg;

  localparam int BEATS_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // A single access, or a burst declared with zero beats, moves exactly one beat.
  function automatic logic [BEATS_W-1:0] beats_of(input logic burst,
                                                  input logic [BEATS_W-1:0] beats);
    if (!burst || beats == '0) return BEATS_W'(1);
    return beats;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request bit at or above ptr, wrapping.
// Reusable for any small ring of requesters.
module rr_pick #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        idx   = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mam_mem_arbiter.sv
// Shares one memory-access port between N_REQ requesters with round-robin
// arbitration at transaction granularity: the grant is held until the last beat.
module mam_mem_arbiter
  import mam_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              in_req_valid,
  output logic [N_REQ-1:0]              in_req_ready,
  input  logic [N_REQ-1:0]              in_req_rw,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [N_REQ-1:0]              in_req_burst,
  input  logic [N_REQ*BEATS_W-1:0]      in_req_beats,
  input  logic [N_REQ-1:0]              in_write_valid,
  output logic [N_REQ-1:0]              in_write_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   in_write_data,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] in_write_strb,
  output logic [N_REQ-1:0]              in_read_valid,
  output logic [DATA_WIDTH-1:0]         in_read_data,
  input  logic [N_REQ-1:0]              in_read_ready,
  output logic                          req_valid,
  output logic                          req_rw,
  output logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          req_burst,
  output logic [BEATS_W-1:0]            req_beats,
  input  logic                          req_ready,
  output logic                          write_valid,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [DATA_WIDTH/8-1:0]       write_strb,
  input  logic                          write_ready,
  input  logic                          read_valid,
  input  logic [DATA_WIDTH-1:0]         read_data,
  output logic                          read_ready,
  output logic [N_REQ-1:0]              grant,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a beat or request transfers on a cycle where valid and ready
  // are both high at the rising clock edge; valid never depends on ready.

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [BEATS_W-1:0] cnt_q, cnt_d;

  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic [N_REQ-1:0]   owner_oh;
  logic               own_req_valid, own_rw, own_burst, own_wvalid, own_rready;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [BEATS_W-1:0] own_beats;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic [SW-1:0]      own_wstrb;
  logic               req_hs, data_hs;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req   (in_req_valid),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    own_req_valid     = in_req_valid[owner_q];
    own_rw            = in_req_rw[owner_q];
    own_burst         = in_req_burst[owner_q];
    own_wvalid        = in_write_valid[owner_q];
    own_rready        = in_read_ready[owner_q];
    own_addr          = in_req_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
    own_beats         = in_req_beats[int'(owner_q)*BEATS_W +: BEATS_W];
    own_wdata         = in_write_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    own_wstrb         = in_write_strb[int'(owner_q)*SW +: SW];
  end

  // Every downstream and upstream path is gated by the registered state, so
  // an asserted reset clears all valid/ready outputs without waiting for a clock.
  always_comb begin
    in_req_ready   = '0;
    in_write_ready = '0;
    in_read_valid  = '0;
    in_read_data   = '0;
    req_valid      = 1'b0;
    req_rw         = 1'b0;
    req_addr       = '0;
    req_burst      = 1'b0;
    req_beats      = '0;
    write_valid    = 1'b0;
    write_data     = '0;
    write_strb     = '0;
    read_ready     = 1'b0;
    grant          = '0;
    busy           = 1'b0;
    case (state_q)
      ST_REQ: begin
        req_valid    = own_req_valid;
        req_rw       = own_rw;
        req_addr     = own_addr;
        req_burst    = own_burst;
        req_beats    = own_beats;
        in_req_ready = req_ready ? owner_oh : '0;
        grant        = owner_oh;
        busy         = 1'b1;
      end
      ST_WRITE: begin
        write_valid    = own_wvalid;
        write_data     = own_wdata;
        write_strb     = own_wstrb;
        in_write_ready = write_ready ? owner_oh : '0;
        grant          = owner_oh;
        busy           = 1'b1;
      end
      ST_READ: begin
        in_read_valid = read_valid ? owner_oh : '0;
        in_read_data  = read_data;
        read_ready    = own_rready;
        grant         = owner_oh;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_hs  = (state_q == ST_REQ) && own_req_valid && req_ready;
  assign data_hs = ((state_q == ST_WRITE) && own_wvalid && write_ready) ||
                   ((state_q == ST_READ) && read_valid && own_rready);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_hs) begin
          cnt_d   = beats_of(own_burst, own_beats);
          state_d = own_rw ? ST_WRITE : ST_READ;
        end
      end
      default: begin
        if (data_hs) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BEATS_W'(1)) begin
            state_d = ST_IDLE;
            ptr_d   = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Self-checking bench for mam_mem_arbiter: randomized requesters and memory
// against a transaction-level round-robin model with an expected-beat queue.
module tb_mam_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int BW = 14;

  logic            clk, rstn;
  logic [N-1:0]    in_req_valid, in_req_ready, in_req_rw, in_req_burst;
  logic [N*AW-1:0] in_req_addr;
  logic [N*BW-1:0] in_req_beats;
  logic [N-1:0]    in_write_valid, in_write_ready;
  logic [N*DW-1:0] in_write_data;
  logic [N*SW-1:0] in_write_strb;
  logic [N-1:0]    in_read_valid, in_read_ready;
  logic [DW-1:0]   in_read_data;
  logic            req_valid, req_rw, req_burst, req_ready;
  logic [AW-1:0]   req_addr;
  logic [BW-1:0]   req_beats;
  logic            write_valid, write_ready, read_valid, read_ready;
  logic [DW-1:0]   write_data, read_data;
  logic [SW-1:0]   write_strb;
  logic [N-1:0]    grant;
  logic            busy;
  logic [1:0]      dbg_state;

  mam_mem_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_addr(in_req_addr), .in_req_burst(in_req_burst), .in_req_beats(in_req_beats),
    .in_write_valid(in_write_valid), .in_write_ready(in_write_ready),
    .in_write_data(in_write_data), .in_write_strb(in_write_strb),
    .in_read_valid(in_read_valid), .in_read_data(in_read_data), .in_read_ready(in_read_ready),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_burst(req_burst),
    .req_beats(req_beats), .req_ready(req_ready),
    .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb),
    .write_ready(write_ready), .read_valid(read_valid), .read_data(read_data),
    .read_ready(read_ready), .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic          burst;
    logic [BW-1:0] beats;
  } txn_t;

  txn_t          tq [N][8];
  int            tq_h [N];
  int            tq_n [N];
  logic [DW-1:0] exp_q [$];
  int            grant_log [$];
  int            m_st;     // 0 idle, 1 request phase, 2 data phase
  int            m_owner, m_ptr, m_left, m_k, beat_cnt;
  int            checks, errors;

  function automatic logic [DW-1:0] wdata_of(int r, logic [AW-1:0] a, int k);
    return {a, 16'(r), 16'(k)};
  endfunction

  function automatic logic [SW-1:0] wstrb_of(logic [AW-1:0] a, int k);
    return SW'(a[7:0]) ^ SW'(k);
  endfunction

  function automatic logic [DW-1:0] rdata_of(logic [AW-1:0] a, int k);
    return {~a, 32'(k)};
  endfunction

  function automatic int nbeats(txn_t t);
    return (t.burst && t.beats != 0) ? int'(t.beats) : 1;
  endfunction

  function automatic bit pend(int r);
    return tq_h[r] < tq_n[r];
  endfunction

  task automatic model_clear();
    m_st = 0; m_owner = 0; m_ptr = 0; m_left = 0; m_k = 0; beat_cnt = 0;
    for (int r = 0; r < N; r++) begin
      tq_h[r] = 0;
      tq_n[r] = 0;
    end
    exp_q.delete();
    grant_log.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_req_valid = '0; in_req_rw = '0; in_req_burst = '0;
    in_req_addr = '0; in_req_beats = '0;
    in_write_valid = '0; in_write_data = '0; in_write_strb = '0;
    in_read_ready = '0;
    req_ready = 1'b0; write_ready = 1'b0; read_valid = 1'b0; read_data = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  task automatic enq(input int r, input logic rw, input logic [AW-1:0] addr,
                     input logic burst, input int beats);
    txn_t t;
    t.rw = rw; t.addr = addr; t.burst = burst; t.beats = BW'(beats);
    tq[r][tq_n[r]] = t;
    tq_n[r]++;
  endtask

  // Drives requesters and memory one cycle at a time (inputs change at negedge),
  // checks outputs against the model and advances the model on handshakes.
  // mode 0: random readiness, mode 1: everything ready; stall holds req_ready low.
  task automatic run_traffic(input int max_cycles, input int mode, input int stall_cycles);
    int            stall, cyc, o;
    txn_t          h, ho;
    bit            dphase, reading, hs;
    logic [N-1:0]  oh;
    logic [DW-1:0] e;
    stall = stall_cycles;
    cyc   = 0;
    while (1) begin
      if (m_st == 0 && !pend(0) && !pend(1)) break;
      if (cyc == max_cycles) begin
        checks++; errors++;
        $display("FAIL traffic_timeout cycles=%0d required completion", cyc);
        break;
      end
      cyc++;
      for (int r = 0; r < N; r++) begin
        h = pend(r) ? tq[r][tq_h[r]] : txn_t'(0);
        dphase = (m_st == 2 && m_owner == r);
        in_req_valid[r] = pend(r) && !dphase;
        in_req_rw[r]    = h.rw;
        in_req_burst[r] = h.burst;
        in_req_addr[r*AW +: AW]  = pend(r) ? h.addr : AW'($urandom);
        in_req_beats[r*BW +: BW] = h.beats;
        if (dphase && h.rw) begin
          in_write_valid[r] = (mode == 1) || ($urandom_range(0, 3) != 0);
          in_write_data[r*DW +: DW] = wdata_of(r, h.addr, m_k);
          in_write_strb[r*SW +: SW] = wstrb_of(h.addr, m_k);
        end else begin
          in_write_valid[r] = 1'($urandom_range(0, 1));
          in_write_data[r*DW +: DW] = {$urandom, $urandom};
          in_write_strb[r*SW +: SW] = SW'($urandom);
        end
        in_read_ready[r] = (mode == 1) || ($urandom_range(0, 3) != 0);
      end
      o  = m_owner;
      ho = tq[o][tq_h[o]];
      if (m_st == 1 && stall > 0) begin
        req_ready = 1'b0;
        stall--;
      end else begin
        req_ready = (mode == 1) || ($urandom_range(0, 2) != 0);
      end
      write_ready = (mode == 1) || ($urandom_range(0, 3) != 0);
      reading = (m_st == 2) && !ho.rw;
      if (reading) begin
        read_valid = (mode == 1) || ($urandom_range(0, 3) != 0);
        read_data  = rdata_of(ho.addr, m_k);
      end else begin
        read_valid = ($urandom_range(0, 3) == 0);
        read_data  = {$urandom, $urandom};
      end
      #1;
      oh = '0;
      oh[o] = 1'b1;
      checks++;
      if (m_st == 0) begin
        if (grant !== '0 || busy !== 1'b0 || req_valid !== 1'b0 || in_req_ready !== '0 ||
            write_valid !== 1'b0 || in_write_ready !== '0 || read_ready !== 1'b0 ||
            in_read_valid !== '0) begin
          errors++;
          $display("FAIL idle_outputs grant=%b busy=%b req_v=%b wr_v=%b rd_rdy=%b in_rd_v=%b required all 0",
                   grant, busy, req_valid, write_valid, read_ready, in_read_valid);
        end
      end else if (grant !== oh || busy !== 1'b1) begin
        errors++;
        $display("FAIL grant got=%b busy=%b required=%b busy=1", grant, busy, oh);
      end else if (m_st == 1) begin
        if (req_valid !== 1'b1 || req_addr !== ho.addr || req_rw !== ho.rw ||
            req_burst !== ho.burst || req_beats !== ho.beats ||
            in_req_ready !== (req_ready ? oh : '0) || write_valid !== 1'b0 ||
            in_read_valid !== '0) begin
          errors++;
          $display("FAIL req_phase valid=%b addr=%h rdy=%b required valid=1 addr=%h rdy=%b",
                   req_valid, req_addr, in_req_ready, ho.addr, (req_ready ? oh : '0));
        end
      end else if (ho.rw) begin
        if (write_valid !== in_write_valid[o] || in_write_ready !== (write_ready ? oh : '0) ||
            in_read_valid !== '0 || read_ready !== 1'b0 || req_valid !== 1'b0) begin
          errors++;
          $display("FAIL write_routing wv=%b in_wr=%b required wv=%b in_wr=%b",
                   write_valid, in_write_ready, in_write_valid[o], (write_ready ? oh : '0));
        end
      end else begin
        if (in_read_valid !== (read_valid ? oh : '0) || read_ready !== in_read_ready[o] ||
            write_valid !== 1'b0 || in_write_ready !== '0 || req_valid !== 1'b0) begin
          errors++;
          $display("FAIL read_routing in_rv=%b rr=%b required in_rv=%b rr=%b",
                   in_read_valid, read_ready, (read_valid ? oh : '0), in_read_ready[o]);
        end
      end
      // model update for the coming rising edge
      if (m_st == 0) begin
        for (int i = 0; i < N; i++) begin
          if (m_st == 0 && pend((m_ptr + i) % N)) begin
            m_owner = (m_ptr + i) % N;
            m_st    = 1;
            grant_log.push_back(m_owner);
          end
        end
      end else if (m_st == 1) begin
        if (req_ready) begin
          m_st   = 2;
          m_k    = 0;
          m_left = nbeats(ho);
          for (int k = 0; k < m_left; k++)
            exp_q.push_back(ho.rw ? wdata_of(o, ho.addr, k) : rdata_of(ho.addr, k));
        end
      end else begin
        hs = ho.rw ? (in_write_valid[o] && write_ready) : (read_valid && in_read_ready[o]);
        if (hs) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_underflow got extra beat required none");
          end else begin
            e = exp_q.pop_front();
            if (ho.rw && (write_data !== e || write_strb !== wstrb_of(ho.addr, m_k))) begin
              errors++;
              $display("FAIL write_data got=%h/%h required=%h/%h",
                       write_data, write_strb, e, wstrb_of(ho.addr, m_k));
            end else if (!ho.rw && in_read_data !== e) begin
              errors++;
              $display("FAIL read_data got=%h required=%h", in_read_data, e);
            end
          end
          beat_cnt++;
          m_k++;
          m_left--;
          if (m_left == 0) begin
            m_st  = 0;
            m_ptr = (o + 1) % N;
            tq_h[o]++;
          end
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    in_req_valid = '1; in_req_rw = '1; in_req_burst = '1;
    in_req_addr = '1; in_req_beats = '1;
    in_write_valid = '1; in_write_data = '1; in_write_strb = '1; in_read_ready = '1;
    req_ready = 1'b1; write_ready = 1'b1; read_valid = 1'b1; read_data = '1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state grant=%b busy=%b state=%0d required 0/0/0", grant, busy, dbg_state);
    end
    checks++;
    if (req_valid !== 1'b0 || in_req_ready !== '0 || write_valid !== 1'b0 ||
        in_write_ready !== '0 || in_read_valid !== '0 || read_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshakes rv=%b irr=%b wv=%b iwr=%b irv=%b rr=%b required 0",
               req_valid, in_req_ready, write_valid, in_write_ready, in_read_valid, read_ready);
    end
    checks++;
    if (req_addr !== '0 || write_data !== '0 || write_strb !== '0 || in_read_data !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h wd=%h ws=%h rd=%h required 0",
               req_addr, write_data, write_strb, in_read_data);
    end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  task automatic test_write_burst();
    do_reset();
    enq(0, 1'b1, 32'h1000, 1'b1, 4);
    run_traffic(100, 1, 0);
    checks++;
    if (beat_cnt !== 4 || grant_log.size() != 1 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL burst4_beats got=%0d grants=%0d required 4 beats 1 grant", beat_cnt, grant_log.size());
    end
    enq(0, 1'b0, 32'h2000, 1'b0, 0);
    enq(1, 1'b0, 32'h3000, 1'b0, 0);
    run_traffic(100, 1, 0);
    checks++;
    if (grant_log.size() != 3 || grant_log[1] != 1 || grant_log[2] != 0) begin
      errors++;
      $display("FAIL ptr_after_burst got first=%0d required 1", grant_log[1]);
    end
  endtask

  task automatic test_two_req();
    do_reset();
    enq(0, 1'b0, 32'h4000, 1'b0, 0);
    enq(1, 1'b1, 32'h5000, 1'b0, 0);
    run_traffic(200, 0, 0);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1 || beat_cnt != 2) begin
      errors++;
      $display("FAIL two_req_order size=%0d beats=%0d required order 0,1 beats 2",
               grant_log.size(), beat_cnt);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 6; i++)
      enq(i % 2, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          $urandom_range(0, 5));
    run_traffic(800, 0, 0);
    checks++;
    if (grant_log.size() != 6) begin
      errors++;
      $display("FAIL fair_count got=%0d required 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != i % 2) begin
          errors++;
          $display("FAIL fair_order idx=%0d got=%0d required=%0d", i, grant_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    enq(0, 1'b1, 32'h6000, 1'b1, 3);
    enq(1, 1'b0, 32'h7000, 1'b1, 2);
    run_traffic(300, 0, 10);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1 || beat_cnt != 5) begin
      errors++;
      $display("FAIL stall_order size=%0d beats=%0d required order 0,1 beats 5",
               grant_log.size(), beat_cnt);
    end
  endtask

  task automatic test_zero_beats();
    do_reset();
    enq(0, 1'b1, 32'h8000, 1'b1, 0);
    run_traffic(100, 0, 0);
    checks++;
    if (beat_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_beats_write got=%0d required 1", beat_cnt);
    end
    enq(1, 1'b0, 32'h8800, 1'b1, 0);
    run_traffic(100, 0, 0);
    checks++;
    if (beat_cnt != 2) begin
      errors++;
      $display("FAIL zero_beats_read got=%0d required 2", beat_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    do_reset();
    in_req_valid = 2'b01; in_req_rw = 2'b01; in_req_burst = 2'b01;
    in_req_addr[AW-1:0] = 32'h9000; in_req_beats[BW-1:0] = 14'd8;
    in_write_valid = 2'b01; req_ready = 1'b1; write_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 30 && hs < 3; c++) begin
      @(negedge clk);
      #1;
      if (write_valid && write_ready) hs++;
    end
    checks++;
    if (hs != 3) begin
      errors++;
      $display("FAIL mid_beats got=%0d required 3", hs);
    end
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL mid_busy busy=%b state=%0d required 1/2", busy, dbg_state);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || write_valid !== 1'b0 || in_write_ready !== '0 ||
        req_valid !== 1'b0 || in_req_ready !== '0 || read_ready !== 1'b0 || in_read_valid !== '0) begin
      errors++;
      $display("FAIL async_reset grant=%b busy=%b wv=%b iwr=%b required 0", grant, busy,
               write_valid, in_write_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    idle_inputs();
    enq(1, 1'b1, 32'hA000, 1'b1, 3);
    run_traffic(100, 0, 0);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 1 || beat_cnt != 3) begin
      errors++;
      $display("FAIL post_reset size=%0d beats=%0d required grant 1 beats 3",
               grant_log.size(), beat_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 8; i++)
      enq($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 6));
    run_traffic(1500, 0, 0);
    checks++;
    if (grant_log.size() != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_done grants=%0d left=%0d required 8/0", grant_log.size(), exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    test_reset();
    test_write_burst();
    test_two_req();
    test_fairness();
    test_stall();
    test_zero_beats();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mam_mem_arbiter.md
Name: mam_mem_arbiter

Overview:
- Shares one memory-access port (req / write / read channels, as driven by osd_mam) between N_REQ requesters.
- Typical requesters are the debug MAM and a second memory master, e.g. a DMA loader or a second MAM.
- Round-robin arbitration happens only at transaction granularity: the grant is held from request acceptance until the last data beat, so beats of different transactions never interleave.
- Sits between the requesters and the memory-side adapter.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 512, data beat width in bits
- ADDR_WIDTH, 64, request address width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_req_valid  in  N_REQ  per-requester request valid
- in_req_ready  out  N_REQ  per-requester request ready
- in_req_rw  in  N_REQ  1 = write, 0 = read
- in_req_addr  in  N_REQ*ADDR_WIDTH  request address
- in_req_burst  in  N_REQ  burst flag
- in_req_beats  in  N_REQ*14  burst length
- in_write_valid  in  N_REQ  write beat valid
- in_write_ready  out  N_REQ  write beat ready
- in_write_data  in  N_REQ*DATA_WIDTH  write data
- in_write_strb  in  N_REQ*DATA_WIDTH/8  byte strobes
- in_read_valid  out  N_REQ  read beat valid
- in_read_data  out  DATA_WIDTH  read data, broadcast to all requesters
- in_read_ready  in  N_REQ  read beat ready
- req_valid, req_rw, req_addr, req_burst, req_beats  out  1,1,ADDR_WIDTH,1,14  downstream request
- req_ready  in  1  downstream request ready
- write_valid, write_data, write_strb  out  1,DATA_WIDTH,DATA_WIDTH/8  downstream write
- write_ready  in  1
- read_valid, read_data  in  1,DATA_WIDTH  downstream read
- read_ready  out  1
- grant  out  N_REQ  one-hot current owner, 0 when idle
- busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- States: IDLE, REQ, WRITE, READ.
- Reset (rstn low, async):
  - state = IDLE, rr pointer = 0, beat counter = 0, owner = 0.
  - grant = 0, busy = 0.
  - All valid/ready outputs = 0.
  - Data outputs are don't-care and are driven to 0.
- IDLE:
  - If any in_req_valid is set, pick the first set bit searching from the rr pointer upward with wrap.
  - Register that requester as owner and go to REQ next cycle. No combinational grant in IDLE; minimum latency is 1 cycle from in_req_valid to req_valid.
- REQ:
  - req_* = owner's in_req_*.
  - in_req_ready[owner] = req_ready; all other bits 0.
  - The grant is locked, so a later higher-priority request cannot preempt.
  - On the req_valid & req_ready handshake:
    - Load the counter with beats = in_req_burst ? in_req_beats : 1. A burst with in_req_beats = 0 is treated as 1.
    - Go to WRITE if rw = 1, else READ.
- WRITE:
  - write_valid = in_write_valid[owner]; write_data and write_strb come from the owner.
  - in_write_ready[owner] = write_ready; other requesters get 0.
  - Each handshake decrements the counter.
  - Handshake with counter = 1 → IDLE, rr pointer = owner+1 mod N_REQ.
- READ:
  - in_read_valid[owner] = read_valid; other bits 0.
  - read_ready = in_read_ready[owner].
  - Decrement and exit exactly as in WRITE.
- Outside WRITE, write_valid = 0 and in_write_ready = 0. Outside READ, read_ready = 0 and in_read_valid = 0.
- A stray downstream read_valid in IDLE/REQ/WRITE is not acknowledged. It is the downstream's protocol error.
- grant = one-hot(owner) in REQ/WRITE/READ; busy = 1 in those states.
- A requester deasserting in_req_valid while in REQ is a protocol violation. The arbiter still holds the grant until the handshake occurs.
- Counter width is 14 bits with no wrap: the maximum of 16383 beats is supported.
- Fairness: a requester continuously requesting waits at most N_REQ-1 transactions.
- Reset mid-transaction aborts immediately and returns to IDLE. Downstream reset coherence is the system's responsibility.

Decomposition:
- A shared package mam_arb_pkg holds:
  - the state enum;
  - the BEATS_W = 14 constant;
  - a function beats_of(burst, beats) implementing the 0→1 rule.
- One sub-module, rr_pick (combinational round-robin first-set search from pointer, parameter N), which is reusable for ring-port arbitration.

Test Plan:
1. Req0 write, burst = 1, beats = 4, addr 0x1000, write_ready held at 1 → downstream sees one request then exactly 4 write beats with req0's data; in_write_ready[1] = 0 throughout; return to IDLE with pointer = 1.
2. Both requesters assert in_req_valid in the first cycle after reset, req0 read single-beat and req1 write single-beat → req0 served first (read_data returned to in_read_valid[0]), then req1; grant sequence 01, 0, 10.
3. Both requesters request continuously for 6 transactions → grant alternates 0, 1, 0, 1, 0, 1.
4. req_ready held 0 for 10 cycles while req1 raises a request → grant stays on req0, req_addr stable, req1 is granted only after req0's final beat.
5. Burst with beats = 0 → exactly 1 data beat transferred, then IDLE.
6. rstn pulled low mid 8-beat write after 3 beats → all valid/ready outputs 0 asynchronously, grant = 0, busy = 0; after release, a new req1 request is granted with a fresh counter.
